// File: rtl/trng_collector.sv
// rtl/trng_collector.sv - TRNG bit collector with repetition-count health test and ready/valid output.
// Optional von Neumann debiasing via `define TRNG_VON_NEUMANN_EN.
module trng_collector #(
    parameter int WIDTH     = 8,
    parameter int REP_LIMIT = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             raw_bit,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    output logic             health_fail
);
    localparam int CW = $clog2(WIDTH);

    logic             r_sample;
    logic             r_sample_vld;
    logic             r_prev;
    logic [7:0]       r_rep_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             r_health;

    logic             w_proc;
    logic [7:0]       w_rep_next;
    logic             w_trip;
    logic             w_bit_vld;
    logic             w_bit;
    logic             w_accept;
    logic             w_last;
    logic             w_complete;
    logic             w_load;
    logic [WIDTH-1:0] w_word;

    assign w_proc = enable & r_sample_vld;

    // Saturates at the limit; health_fail is sticky so the exact count beyond it is irrelevant.
    always_comb begin
        w_rep_next = 8'd1;
        if ((r_rep_cnt != 8'd0) && (r_sample == r_prev)) begin
            w_rep_next = (r_rep_cnt == 8'(REP_LIMIT)) ? r_rep_cnt : r_rep_cnt + 8'd1;
        end
    end

    assign w_trip = w_proc & (w_rep_next == 8'(REP_LIMIT));

`ifdef TRNG_VON_NEUMANN_EN
    typedef enum logic {PAIR_FIRST, PAIR_SECOND} pair_t;

    pair_t r_pair;
    pair_t w_pair_next;
    logic  r_first;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pair  <= PAIR_FIRST;
            r_first <= 1'b0;
        end else begin
            r_pair <= w_pair_next;
            if (!enable) begin
                r_first <= 1'b0;
            end else if (w_proc && (r_pair == PAIR_FIRST)) begin
                r_first <= r_sample;
            end
        end
    end

    always_comb begin
        w_pair_next = r_pair;
        w_bit_vld   = 1'b0;
        w_bit       = 1'b0;
        if (!enable) begin
            w_pair_next = PAIR_FIRST;
        end else if (w_proc) begin
            case (r_pair)
                PAIR_FIRST: w_pair_next = PAIR_SECOND;
                PAIR_SECOND: begin
                    w_pair_next = PAIR_FIRST;
                    if (r_first != r_sample) begin
                        w_bit_vld = 1'b1;
                        w_bit     = r_first;
                    end
                end
                default: w_pair_next = PAIR_FIRST;
            endcase
        end
    end
`else
    assign w_bit_vld = w_proc;
    assign w_bit     = r_sample;
`endif

    // The sample that trips the health test never makes it into a word.
    assign w_accept   = w_bit_vld & ~r_health & ~w_trip;
    assign w_last     = (r_bit_cnt == CW'(WIDTH - 1));
    assign w_word     = {r_shift[WIDTH-2:0], w_bit};
    assign w_complete = w_accept & w_last;
    assign w_load     = w_complete & (~r_valid | data_ready);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sample     <= 1'b0;
            r_sample_vld <= 1'b0;
            r_prev       <= 1'b0;
            r_rep_cnt    <= 8'd0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
            r_health     <= 1'b0;
        end else begin
            if (enable) begin
                r_sample     <= raw_bit;
                r_sample_vld <= 1'b1;
            end else begin
                r_sample_vld <= 1'b0;
            end

            if (!enable) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_rep_cnt <= 8'd0;
            end else if (w_proc) begin
                r_rep_cnt <= w_rep_next;
                r_prev    <= r_sample;
                if (w_accept) begin
                    r_shift   <= w_word;
                    r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
                end
            end

            if (w_trip) begin
                r_health <= 1'b1;
            end

            if (w_load) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end

            if (w_complete && !w_load) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign data_out    = r_data;
    assign data_valid  = r_valid;
    assign overrun     = r_overrun;
    assign health_fail = r_health;
endmodule

// File: tb/tb_trng_collector.sv
// tb/tb_trng_collector.sv - Self-checking bench for trng_collector against a bit-queue reference model.
module tb_trng_collector;
    localparam int WIDTH     = 8;
    localparam int REP_LIMIT = 16;

    logic             clock       = 1'b0;
    logic             reset_n     = 1'b0;
    logic             enable      = 1'b0;
    logic             raw_bit     = 1'b0;
    logic             data_ready  = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             overrun;
    logic             health_fail;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit               m_sv;
    bit               m_s;
    int               m_run;
    bit               m_last;
    int               m_bits[$];
    bit               m_valid;
    bit               m_ovr;
    bit               m_hf;
    logic [WIDTH-1:0] m_out;
    bit               m_have_first;
    bit               m_first;

    always #5 clock = ~clock;

    trng_collector #(.WIDTH(WIDTH), .REP_LIMIT(REP_LIMIT)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .raw_bit    (raw_bit),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .health_fail(health_fail)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sv = 0; m_s = 0; m_run = 0; m_last = 0;
        m_bits.delete();
        m_valid = 0; m_ovr = 0; m_hf = 0; m_out = '0;
        m_have_first = 0; m_first = 0;
    endtask

    task automatic model_edge(input bit en, input bit b, input bit rdy);
        bit               load = 0;
        bit               trip = 0;
        bit               have = 0;
        bit               nb   = 0;
        logic [WIDTH-1:0] word = '0;
        if (en && m_sv) begin
            m_run  = (m_run > 0 && m_s == m_last) ? m_run + 1 : 1;
            m_last = m_s;
            trip   = (m_run >= REP_LIMIT);
`ifdef TRNG_VON_NEUMANN_EN
            if (!m_have_first) begin
                m_first      = m_s;
                m_have_first = 1;
            end else begin
                m_have_first = 0;
                if (m_first != m_s) begin
                    have = 1;
                    nb   = m_first;
                end
            end
`else
            have = 1;
            nb   = m_s;
`endif
            if (have && !m_hf && !trip) begin
                m_bits.push_back(int'(nb));
                if (m_bits.size() == WIDTH) begin
                    foreach (m_bits[i]) word = (word << 1) | WIDTH'(m_bits[i]);
                    m_bits.delete();
                    if (!m_valid || rdy) load = 1;
                    else m_ovr = 1;
                end
            end
            if (trip) m_hf = 1;
        end
        if (load) begin
            m_out   = word;
            m_valid = 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (en) begin
            m_sv = 1;
            m_s  = b;
        end else begin
            m_sv = 0;
            m_run = 0;
            m_bits.delete();
            m_have_first = 0;
        end
    endtask

    task automatic compare_all();
        chk("data_valid", data_valid, m_valid);
        chk("data_out", data_out, m_out);
        chk("overrun", overrun, m_ovr);
        chk("health_fail", health_fail, m_hf);
    endtask

    task automatic step(input bit en, input bit b, input bit rdy);
        enable     = en;
        raw_bit    = b;
        data_ready = rdy;
        @(posedge clock);
        model_edge(en, b, rdy);
        #1;
        compare_all();
    endtask

    task automatic send_word(input logic [31:0] w, input bit rdy);
        for (int i = WIDTH - 1; i >= 0; i--) step(1'b1, w[i], rdy);
    endtask

    initial begin
        int dv_count;
        logic [31:0] rw;

        model_reset();
        #12;
        chk("rst_data_out", data_out, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_health_fail", health_fail, 0);
        @(negedge clock);
        reset_n = 1'b1;

`ifdef TRNG_VON_NEUMANN_EN
        step(0, 0, 1);
        for (int r = 0; r < 4; r++) begin
            step(1, 1, 1); step(1, 0, 1);
            step(1, 0, 1); step(1, 0, 1);
            step(1, 0, 1); step(1, 1, 1);
            step(1, 1, 1); step(1, 1, 1);
        end
        step(1, 0, 1);
        chk("vn_out_aa", data_out, 32'hAA);
        chk("vn_overrun", overrun, 0);
`else
        step(0, 0, 1);
        send_word(32'hB2, 1);
        step(1, 0, 1);
        chk("b2_out", data_out, 32'hB2);
        chk("b2_valid", data_valid, 1);
        step(1, 1, 1);
        chk("b2_pulse", data_valid, 0);
`endif

        step(0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 1'($urandom_range(0, 1)), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        send_word(32'hC3, 1);
        step(1, 0, 1);
`ifndef TRNG_VON_NEUMANN_EN
        chk("c3_out", data_out, 32'hC3);
        chk("c3_valid", data_valid, 1);
`endif

        step(0, 0, 1);
        send_word(32'h5A, 0);
        send_word(32'h3C, 0);
        step(1, 0, 0);
`ifndef TRNG_VON_NEUMANN_EN
        chk("hold_5a", data_out, 32'h5A);
        chk("overrun_set", overrun, 1);
`endif
        step(0, 0, 1);
        chk("handshake_clear", data_valid, 0);
        rw = $urandom;
        send_word(rw, 0);
        step(1, 0, 0);

        @(negedge clock);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_data_out", data_out, 0);
        chk("async_data_valid", data_valid, 0);
        chk("async_overrun", overrun, 0);
        chk("async_health_fail", health_fail, 0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) != 0));
        end

        step(0, 0, 1);
        for (int i = 0; i < REP_LIMIT; i++) step(1, 1, 1);
        step(1, 0, 1);
        chk("health_tripped", health_fail, 1);
        dv_count = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, 1'(i % 2), 1);
            if (data_valid) dv_count++;
        end
        chk("no_valid_after_fail", dv_count, 0);
        chk("health_sticky", health_fail, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/trng_collector.md
TRNG_COLLECTOR -- requirements
Module: trng_collector

Interface
REQ-001 Parameter WIDTH, default 8: bits per output word, range 2..32.
REQ-002 Parameter REP_LIMIT, default 16: consecutive identical raw samples that trip the health test, range 2..255.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  collection enable, synchronous to clock.
REQ-006 raw_bit  input  1  raw entropy bit from the ring-oscillator combiner, synchronous to clock.
REQ-007 data_out  output  WIDTH  collected random word.
REQ-008 data_valid  output  1  data_out holds an unconsumed word.
REQ-009 data_ready  input  1  consumer accepts data_out.
REQ-010 overrun  output  1  sticky: at least one completed word was dropped.
REQ-011 health_fail  output  1  sticky: the repetition-count health test has tripped.

Function
REQ-012 When enable=1, raw_bit SHALL be captured into a sample register on every edge; the sample SHALL be processed on the following edge. Total latency from the last raw bit to data_valid is 2 edges.
REQ-013 Each accepted bit SHALL be shifted into bit 0 of a WIDTH-bit shifter, with earlier bits moving toward the MSB. A bit counter SHALL count 0..WIDTH-1.
REQ-014 On the edge that accepts the WIDTH-th bit, the full word SHALL load into data_out and data_valid SHALL set, if data_valid=0 or data_ready=1 in that cycle; the bit counter then SHALL wrap to 0.
REQ-015 If data_valid=1 and data_ready=0 when a word completes, that word SHALL be discarded, overrun SHALL set, and data_out SHALL stay unchanged.
REQ-016 A handshake completes when data_valid=1 and data_ready=1. If no new word loads on the same edge, data_valid SHALL clear. data_out SHALL be stable while data_valid=1 and data_ready=0.
REQ-017 The repetition counter SHALL increment when a sample equals the previous sample and reload to 1 otherwise. health_fail SHALL set on the edge the count reaches REP_LIMIT.
REQ-018 While health_fail=1, no new word SHALL load and the shifter SHALL be held. A word already pending SHALL still complete its handshake.
REQ-019 When enable=0:
  - sampling SHALL stop;
  - the bit counter, pair state, sample-valid flag and repetition counter SHALL clear;
  - the partial word SHALL be discarded;
  - data_out, data_valid, overrun and health_fail SHALL hold.
REQ-020 The handshake of REQ-016 SHALL operate regardless of enable.

Reset
REQ-021 While reset_n=0, asynchronously:
  - data_out=0, data_valid=0, overrun=0, health_fail=0;
  - shifter, counters, sample register and pair state = 0.
REQ-022 overrun and health_fail SHALL clear only by reset.
REQ-023 Reset asserted mid-word or with a pending word SHALL discard all data. The first sample SHALL be captured on the first edge after deassertion with enable=1.

Configuration
REQ-024 Macro TRNG_VON_NEUMANN_EN SHALL enable von Neumann debiasing. It uses a two-state pair FSM:
  - FIRST: stores the sample, goes to SECOND.
  - SECOND: pair (first,second) = 1,0 accepts bit 1; pair 0,1 accepts bit 0; pairs 0,0 and 1,1 accept nothing; always returns to FIRST.
REQ-025 Without TRNG_VON_NEUMANN_EN, every processed sample SHALL be accepted as a bit directly, and no pair FSM SHALL exist.
REQ-026 The health test of REQ-017 SHALL operate on raw samples in both configurations.

Verification
REQ-027 No VN, WIDTH=8, data_ready=1, enable=1; raw_bit 1,0,1,1,0,0,1,0 on consecutive edges -> data_out=8'hB2 and data_valid=1 for exactly one cycle, 2 edges after the last bit.
REQ-028 VN on; raw pairs (1,0),(0,0),(0,1),(1,1) repeated 4 times -> data_out=8'hAA after 16 pairs; overrun=0.
REQ-029 No VN, data_ready=0, 16 bits forming 8'h5A then 8'h3C -> data_out=8'h5A held, overrun=1. Then data_ready=1 for one cycle -> data_valid=0.
REQ-030 raw_bit held 1 for 16 edges, REP_LIMIT=16 -> health_fail=1. No further data_valid even with alternating input thereafter.
REQ-031 No VN; 5 bits, then enable=0 for 3 cycles, then enable=1 with bits forming 8'hC3 -> data_out=8'hC3, no stale bits.
REQ-032 data_valid=1 with overrun=1; assert reset_n=0 mid-cycle -> all outputs 0 immediately, before the next edge.
